// File: rtl/axi_rd_out_fifo.sv
// axi_rd_out_fifo: first-word-fall-through FIFO between the compute core
// (valid/ready push side) and the AXI4 read-channel FSM (empty/pop side).
// Pointers carry one extra wrap bit, so full and empty can be told apart
// without a separate occupancy register. All status flags come only from
// the registered pointers. The head word is a combinational read of the array.
//
// Optional build macro: AXI_RD_OUT_FIFO_OVF_EN
//   defined   -> ovf_err is a sticky flag. It sets when push_valid is seen
//                while the FIFO is full, and clears only on reset.
//   undefined -> ovf_err is tied to 0 and no flag register exists.
module axi_rd_out_fifo #(
  parameter int DATA_W    = 32,
  parameter int DEPTH     = 16,
  parameter int AF_THRESH = 12
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic [DATA_W-1:0]          push_data,
  input  logic                       push_valid,
  output logic                       push_ready,
  output logic                       out_fifo_empty,
  input  logic                       out_fifo_pop,
  output logic [DATA_W-1:0]          out_fifo_rdata,
  output logic [$clog2(DEPTH):0]     out_fifo_count,
  output logic                       almost_full,
  output logic                       ovf_err
);

  localparam int AW = $clog2(DEPTH);
  localparam int PW = AW + 1;
  localparam logic [PW-1:0] AF_LVL = PW'(AF_THRESH);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wr_ptr;
  logic [PW-1:0]     rd_ptr;
  logic              full;
  logic              empty;
  logic              push_fire;
  logic              pop_fire;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) && (wr_ptr[AW] != rd_ptr[AW]);
  assign push_fire = push_valid && !full;
  // A pop while empty is deliberately a no-op; the FSM pops speculatively.
  assign pop_fire  = out_fifo_pop && !empty;

  assign push_ready     = !full;
  assign out_fifo_empty = empty;
  assign out_fifo_count = wr_ptr - rd_ptr;
  assign almost_full    = (out_fifo_count >= AF_LVL);
  assign out_fifo_rdata = mem[rd_ptr[AW-1:0]];

  // Pointer update: reset discards contents, otherwise advance on accepted push/pop.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push_fire) wr_ptr <= wr_ptr + 1'b1;
      if (pop_fire)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage write; no reset on the array itself, and no write in a reset cycle.
  always_ff @(posedge clk) begin
    if (reset && push_fire) mem[wr_ptr[AW-1:0]] <= push_data;
  end

`ifdef AXI_RD_OUT_FIFO_OVF_EN
  logic ovf_q;

  // Sticky overflow: any push attempt against a full FIFO, held until reset.
  always_ff @(posedge clk) begin
    if (!reset)                  ovf_q <= 1'b0;
    else if (push_valid && full) ovf_q <= 1'b1;
  end

  assign ovf_err = ovf_q;
`else
  assign ovf_err = 1'b0;
`endif

endmodule

// File: tb/tb_axi_rd_out_fifo.sv
// Bench for axi_rd_out_fifo. The reference model is a queue of beats;
// it gives the expected flags, count and head word after every edge.
module tb_axi_rd_out_fifo;

  localparam int DATA_W    = 32;
  localparam int DEPTH     = 16;
  localparam int AF_THRESH = 12;
  localparam int CW        = $clog2(DEPTH) + 1;

  logic              clk = 1'b0;
  logic              reset = 1'b0;
  logic [DATA_W-1:0] push_data = '0;
  logic              push_valid = 1'b0;
  logic              push_ready;
  logic              out_fifo_empty;
  logic              out_fifo_pop = 1'b0;
  logic [DATA_W-1:0] out_fifo_rdata;
  logic [CW-1:0]     out_fifo_count;
  logic              almost_full;
  logic              ovf_err;

  logic [DATA_W-1:0] mq[$];
  bit                m_ovf = 1'b0;
  int                n_cmp = 0;
  int                n_err = 0;

  axi_rd_out_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH), .AF_THRESH(AF_THRESH)) dut (
    .clk            (clk),
    .reset          (reset),
    .push_data      (push_data),
    .push_valid     (push_valid),
    .push_ready     (push_ready),
    .out_fifo_empty (out_fifo_empty),
    .out_fifo_pop   (out_fifo_pop),
    .out_fifo_rdata (out_fifo_rdata),
    .out_fifo_count (out_fifo_count),
    .almost_full    (almost_full),
    .ovf_err        (ovf_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // One clock: drive inputs, advance the model, then compare every output.
  task automatic cycle(input logic rst_b, input logic pv, input logic [DATA_W-1:0] pd,
                       input logic pp);
    bit full_pre;
    bit acc;
    bit pop_ok;
    reset        = rst_b;
    push_valid   = pv;
    push_data    = pd;
    out_fifo_pop = pp;
    full_pre = (mq.size() == DEPTH);
    acc      = pv && !full_pre;
    pop_ok   = pp && (mq.size() != 0);
    @(posedge clk);
    if (!rst_b) begin
      mq.delete();
      m_ovf = 1'b0;
    end else begin
      if (pop_ok) void'(mq.pop_front());
      if (acc) mq.push_back(pd);
`ifdef AXI_RD_OUT_FIFO_OVF_EN
      if (pv && full_pre) m_ovf = 1'b1;
`endif
    end
    #1;
    check("empty", 32'(out_fifo_empty), 32'(mq.size() == 0));
    check("push_ready", 32'(push_ready), 32'(mq.size() != DEPTH));
    check("count", 32'(out_fifo_count), 32'(mq.size()));
    check("almost_full", 32'(almost_full), 32'(mq.size() >= AF_THRESH));
    check("ovf_err", 32'(ovf_err), 32'(m_ovf));
    if (mq.size() != 0) check("rdata", out_fifo_rdata, mq[0]);
  endtask

  initial begin
    int pprob;
    // Reset held for two edges, then idle and a speculative pop while empty.
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b0, 1'b0, '0, 1'b0);
    cycle(1'b1, 1'b0, '0, 1'b0);
    check("rst_empty", 32'(out_fifo_empty), 32'd1);
    check("rst_count", 32'(out_fifo_count), 32'd0);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("pop_when_empty_count", 32'(out_fifo_count), 32'd0);

    // FWFT latency.
    cycle(1'b1, 1'b1, 32'hA5A5_0001, 1'b0);
    check("fwft_not_empty", 32'(out_fifo_empty), 32'd0);
    check("fwft_rdata", out_fifo_rdata, 32'hA5A5_0001);
    cycle(1'b1, 1'b0, '0, 1'b1);
    check("fwft_empty_after_pop", 32'(out_fifo_empty), 32'd1);

    // Fill to full; almost_full threshold and full boundary.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(1'b1, 1'b1, DATA_W'(i), 1'b0);
      if (i == AF_THRESH - 2) check("af_below_thresh", 32'(almost_full), 32'd0);
      if (i == AF_THRESH - 1) check("af_at_thresh", 32'(almost_full), 32'd1);
    end
    check("full_ready", 32'(push_ready), 32'd0);
    check("full_count", 32'(out_fifo_count), 32'd16);
    // Push against full with a simultaneous pop: push rejected.
    cycle(1'b1, 1'b1, 32'd16, 1'b1);
    check("full_pushpop_count", 32'(out_fifo_count), 32'd15);
    check("full_pushpop_ready", 32'(push_ready), 32'd1);
`ifdef AXI_RD_OUT_FIFO_OVF_EN
    check("ovf_set", 32'(ovf_err), 32'd1);
`else
    check("ovf_tied_low", 32'(ovf_err), 32'd0);
`endif
    for (int i = 1; i < DEPTH; i++) begin
      check("drain_order", out_fifo_rdata, DATA_W'(i));
      cycle(1'b1, 1'b0, '0, 1'b1);
    end
`ifdef AXI_RD_OUT_FIFO_OVF_EN
    check("ovf_sticky", 32'(ovf_err), 32'd1);
`else
    check("ovf_still_low", 32'(ovf_err), 32'd0);
`endif

    // Wrap-around with steady-state simultaneous push+pop.
    cycle(1'b1, 1'b1, 32'd0, 1'b0);
    for (int i = 1; i < 40; i++) begin
      check("wrap_order", out_fifo_rdata, DATA_W'(i - 1));
      cycle(1'b1, 1'b1, DATA_W'(i), 1'b1);
    end
    check("wrap_last", out_fifo_rdata, 32'd39);
    cycle(1'b1, 1'b0, '0, 1'b1);

    // Reset mid-burst.
    for (int i = 0; i < 5; i++) cycle(1'b1, 1'b1, DATA_W'(32'h100 + i), 1'b0);
    cycle(1'b0, 1'b1, 32'hDEAD_BEEF, 1'b1);
    check("midrst_count", 32'(out_fifo_count), 32'd0);
    check("midrst_empty", 32'(out_fifo_empty), 32'd1);
    cycle(1'b1, 1'b1, 32'h1234, 1'b0);
    check("midrst_first", out_fifo_rdata, 32'h1234);

    // Randomized traffic with phases biased toward filling and draining.
    for (int k = 0; k < 800; k++) begin
      pprob = ((k / 100) % 2 == 0) ? 80 : 25;
      cycle(($urandom_range(0, 99) != 0),
            ($urandom_range(0, 99) < pprob),
            DATA_W'($urandom),
            ($urandom_range(0, 99) < 50));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
